rx: RTL

- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Deserialises frames from the serial line: 1 start bit (low), WIDTH_WORD_RX data bits sent MSB first, CANT_BIT_STOP stop bits (high).
- Oversamples at 16 ticks per bit, using the same baud-rate tick generator that drives the transmitter.
- Sits between the serial pin and the interface/ALU logic; presents the received word with a one-clock done pulse.

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_sync.sv | 21 ++
 rtl/rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared UART constants and state encodings, common to the receiver and transmitter.
package rx_pkg;

  localparam int WIDTH_WORD    = 8;
  localparam int CANT_BIT_STOP = 2;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [3:0] {
    ESPERA = 4'b0001,
    START  = 4'b0010,
    READ   = 4'b0100,
    STOP   = 4'b1000
  } state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic line_s
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b1;
      line_s <= 1'b1;
    end else begin
      meta   <= line;
      line_s <= meta;
    end
  end

endmodule

// File: rtl/rx.sv
// UART receiver: 16x oversampled, MSB-first data, configurable stop bits, one-clock done pulse.
//
// state  | meaning
// ESPERA | line idle, waiting for a low sample
// START  | counting to mid start bit to reject glitches
// READ   | sampling data bits at mid-bit
// STOP   | sampling stop bits, publishing the word on the last one
module rx
  import rx_pkg::*;
#(
  parameter int WIDTH_WORD_RX = rx_pkg::WIDTH_WORD,
  parameter int CANT_BIT_STOP = rx_pkg::CANT_BIT_STOP,
  parameter int TICKS_PER_BIT = rx_pkg::TICKS_PER_BIT
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rate,
  input  logic                     i_bit_rx,
  output logic [WIDTH_WORD_RX-1:0] o_data_out,
  output logic                     o_rx_done,
  output logic                     o_frame_error
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(WIDTH_WORD_RX) + 1;
  localparam int SW = $clog2(CANT_BIT_STOP) + 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_WORD_RX - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(CANT_BIT_STOP - 1);

  logic rx_s;

  state_t                   state, state_n;
  logic [TW-1:0]            tick_cnt, tick_cnt_n;
  logic [BW-1:0]            bit_cnt, bit_cnt_n;
  logic [SW-1:0]            stop_cnt, stop_cnt_n;
  logic [WIDTH_WORD_RX-1:0] shreg, shreg_n;
  logic                     err, err_n, err_final;
  logic [WIDTH_WORD_RX-1:0] data_n;
  logic                     done_n;
  logic                     frame_error_n;

  rx_sync u_sync (
    .clock  (i_clock),
    .reset  (i_reset),
    .line   (i_bit_rx),
    .line_s (rx_s)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ESPERA;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= '0;
      shreg         <= '0;
      err           <= 1'b0;
      o_data_out    <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_cnt_n;
      bit_cnt       <= bit_cnt_n;
      stop_cnt      <= stop_cnt_n;
      shreg         <= shreg_n;
      err           <= err_n;
      o_data_out    <= data_n;
      o_rx_done     <= done_n;
      o_frame_error <= frame_error_n;
    end
  end

  // The final stop sample must be folded into the published error flag on the same clock.
  assign err_final = err | ~rx_s;

  always_comb begin
    state_n       = state;
    tick_cnt_n    = tick_cnt;
    bit_cnt_n     = bit_cnt;
    stop_cnt_n    = stop_cnt;
    shreg_n       = shreg;
    err_n         = err;
    data_n        = o_data_out;
    done_n        = 1'b0;
    frame_error_n = o_frame_error;

    case (state)
      ESPERA: begin
        if (i_rate && !rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end

      START: begin
        if (i_rate) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_n = '0;
            if (!rx_s) begin
              state_n   = READ;
              bit_cnt_n = '0;
              err_n     = 1'b0;
            end else begin
              state_n = ESPERA;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      READ: begin
        if (i_rate) begin
          if (tick_cnt == TICK_LAST) begin
            shreg_n    = {shreg[WIDTH_WORD_RX-2:0], rx_s};
            bit_cnt_n  = bit_cnt + BW'(1);
            tick_cnt_n = '0;
            if (bit_cnt == BIT_LAST) begin
              state_n    = STOP;
              stop_cnt_n = '0;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      STOP: begin
        if (i_rate) begin
          if (tick_cnt == TICK_LAST) begin
            err_n      = err_final;
            stop_cnt_n = stop_cnt + SW'(1);
            tick_cnt_n = '0;
            if (stop_cnt == STOP_LAST) begin
              data_n        = shreg;
              frame_error_n = err_final;
              done_n        = 1'b1;
              state_n       = ESPERA;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      default: begin
        state_n    = ESPERA;
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
        stop_cnt_n = '0;
      end
    endcase
  end

endmodule
